// File: rtl/hub75_scan_pkg.sv
// Shared types and helpers for the HUB75 scan sequencer.
//   state_e       : scan FSM states
//   CFG_W         : width of the BCM on-time configuration
//   is_lit_state  : states in which the panel may be lit while the timer runs
package hub75_scan_pkg;

  localparam int unsigned CFG_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_WAIT  = 3'd2,
    ST_BLANK = 3'd3,
    ST_LATCH = 3'd4,
    ST_DRAIN = 3'd5
  } state_e;

  // BLANK, LATCH and IDLE always force the LEDs off.
  function automatic logic is_lit_state(input state_e s);
    return (s == ST_SHIFT) || (s == ST_WAIT) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/hub75_scan_if.sv
// Line-buffer read port plus HUB75 PHY signals driven by the scan sequencer.
//   master : the sequencer (drives read strobe/address and all PHY controls)
//   slave  : line buffer + pad PHY side
interface hub75_scan_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 6,
  parameter int unsigned ROW_W  = 5
) ();
  logic              buf_rd_en;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic [DATA_W-1:0] buf_rd_data;
  logic              frame_done;
  logic [ROW_W-1:0]  phy_addr;
  logic              phy_addr_inc;
  logic              phy_addr_rst;
  logic [DATA_W-1:0] phy_data;
  logic              phy_clk;
  logic              phy_le;
  logic              phy_blank;

  modport master (
    output buf_rd_en, buf_rd_addr, frame_done,
    output phy_addr, phy_addr_inc, phy_addr_rst, phy_data, phy_clk, phy_le, phy_blank,
    input  buf_rd_data
  );

  modport slave (
    input  buf_rd_en, buf_rd_addr, frame_done,
    input  phy_addr, phy_addr_inc, phy_addr_rst, phy_data, phy_clk, phy_le, phy_blank,
    output buf_rd_data
  );
endinterface

// File: rtl/hub75_scan_bcm_timer.sv
// Loadable BCM on-time down-counter.
//   clk, rst      : clock, synchronous active-high reset
//   load_i        : load (base_i + 1) << shift_i
//   base_i        : LSB-plane on-time minus 1
//   shift_i       : bit-plane index (binary weight)
//   zero_o        : counter is zero this cycle
//   zero_next_c   : counter will be zero next cycle
module hub75_scan_bcm_timer #(
  parameter int unsigned BASE_W  = 8,
  parameter int unsigned SHIFT_W = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [BASE_W-1:0]  base_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic               zero_o,
  output logic               zero_next_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q;

  // Load overrides the free-running decrement; counter parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (CNT_W'(base_i) + CNT_W'(1)) << shift_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign zero_next_c = (cnt_d == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_next_c;
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/hub75_scan.sv
// HUB75 scan/shift sequencer with binary-coded-modulation display timing.
//   clk, rst       : clock, synchronous active-high reset
//   ctrl_run_i     : 1 = scan continuously, 0 = finish current display and idle blanked
//   cfg_bcm_len_i  : LSB-plane on-time minus 1 (clk cycles), sampled at LATCH
//   bus (master)   : line-buffer read port {row, plane, col} and PHY outputs
// Shifting of the next line overlaps display of the current one.
module hub75_scan
  import hub75_scan_pkg::*;
#(
  parameter int unsigned N_BANKS  = 2,
  parameter int unsigned N_ROWS   = 32,
  parameter int unsigned N_COLS   = 64,
  parameter int unsigned N_CHANS  = 3,
  parameter int unsigned N_PLANES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_run_i,
  input  logic [CFG_W-1:0] cfg_bcm_len_i,
  hub75_scan_if.master     bus
);

  localparam int unsigned LOG_N_ROWS   = $clog2(N_ROWS);
  localparam int unsigned LOG_N_COLS   = $clog2(N_COLS);
  localparam int unsigned LOG_N_PLANES = $clog2(N_PLANES);
  localparam int unsigned COL_W        = LOG_N_COLS + 1;
  localparam int unsigned ADDR_W       = LOG_N_ROWS + LOG_N_PLANES + LOG_N_COLS;
  localparam int unsigned DATA_W       = N_BANKS * N_CHANS;
  localparam int unsigned TIMER_W      = CFG_W + N_PLANES;

  localparam logic [LOG_N_ROWS-1:0]   ROW_LAST   = LOG_N_ROWS'(N_ROWS - 1);
  localparam logic [LOG_N_PLANES-1:0] PLANE_LAST = LOG_N_PLANES'(N_PLANES - 1);
  localparam logic [COL_W-1:0]        COL_END    = COL_W'(N_COLS);

  state_e                  state_q, state_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [LOG_N_ROWS-1:0]   row_q, row_d;
  logic [LOG_N_PLANES-1:0] plane_q, plane_d;

  logic                    rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
  logic                    phy_clk_q, phy_clk_d;
  logic                    phy_le_q, phy_le_d;
  logic                    blank_q, blank_d;
  logic [LOG_N_ROWS-1:0]   addr_q, addr_d;
  logic                    addr_inc_q, addr_inc_d;
  logic                    addr_rst_q, addr_rst_d;
  logic                    frame_done_q, frame_done_d;

  logic                    timer_load_c;
  logic                    timer_zero;
  logic                    timer_zero_next_c;

  assign timer_load_c = (state_q == ST_LATCH);

  hub75_scan_bcm_timer #(
    .BASE_W  (CFG_W),
    .SHIFT_W (LOG_N_PLANES),
    .CNT_W   (TIMER_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .load_i      (timer_load_c),
    .base_i      (cfg_bcm_len_i),
    .shift_i     (plane_q),
    .zero_o      (timer_zero),
    .zero_next_c (timer_zero_next_c)
  );

  // Next-state, pointer and output computation. Outputs are derived from the
  // next state so that the registered outputs line up with the state register.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    plane_d      = plane_q;
    addr_d       = addr_q;
    addr_inc_d   = 1'b0;
    addr_rst_d   = 1'b0;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        row_d   = '0;
        plane_d = '0;
        if (ctrl_run_i) begin
          state_d = ST_SHIFT;
          col_d   = '0;
        end
      end
      ST_SHIFT: begin
        // col counts 0..N_COLS: reads on 0..N_COLS-1, shift clocks on 1..N_COLS.
        if (col_q == COL_END) begin
          state_d = ST_WAIT;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      ST_WAIT: begin
        if (timer_zero) begin
          state_d = ST_BLANK;
        end
      end
      ST_BLANK: begin
        // New row is presented during the LATCH cycle, which is always blanked.
        state_d    = ST_LATCH;
        addr_d     = row_q;
        addr_inc_d = (row_q != addr_q) && (row_q != '0);
        addr_rst_d = (row_q != addr_q) && (row_q == '0);
      end
      ST_LATCH: begin
        frame_done_d = (row_q == ROW_LAST) && (plane_q == PLANE_LAST);
        if (plane_q == PLANE_LAST) begin
          plane_d = '0;
          row_d   = (row_q == ROW_LAST) ? '0 : row_q + LOG_N_ROWS'(1);
        end else begin
          plane_d = plane_q + LOG_N_PLANES'(1);
        end
        if (ctrl_run_i) begin
          state_d = ST_SHIFT;
          col_d   = '0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (timer_zero) begin
          state_d = ST_IDLE;
          row_d   = '0;
          plane_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rd_en_d   = (state_d == ST_SHIFT) && (col_d < COL_END);
    rd_addr_d = rd_en_d ? {row_d, plane_d, col_d[LOG_N_COLS-1:0]} : '0;
    phy_clk_d = (state_d == ST_SHIFT) && (col_d != '0);
    phy_le_d  = (state_d == ST_LATCH);
    blank_d   = !(is_lit_state(state_d) && !timer_zero_next_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      plane_q      <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      phy_clk_q    <= 1'b0;
      phy_le_q     <= 1'b0;
      blank_q      <= 1'b1;
      addr_q       <= '0;
      addr_inc_q   <= 1'b0;
      addr_rst_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      phy_clk_q    <= phy_clk_d;
      phy_le_q     <= phy_le_d;
      blank_q      <= blank_d;
      addr_q       <= addr_d;
      addr_inc_q   <= addr_inc_d;
      addr_rst_q   <= addr_rst_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.buf_rd_en    = rd_en_q;
  assign bus.buf_rd_addr  = rd_addr_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.phy_addr     = addr_q;
  assign bus.phy_addr_inc = addr_inc_q;
  assign bus.phy_addr_rst = addr_rst_q;
  assign bus.phy_clk      = phy_clk_q;
  assign bus.phy_le       = phy_le_q;
  assign bus.phy_blank    = blank_q;
  // Read data is already registered by the buffer; gate it so it is zero between shift clocks.
  assign bus.phy_data     = bus.buf_rd_data & {DATA_W{phy_clk_q}};

endmodule

// File: tb/tb_hub75_scan.sv
// Scoreboard bench for hub75_scan on a small panel (4 rows x 4 cols x 3 planes).
// Stimulus pushes expected shift data, lit-run lengths and latch events;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_hub75_scan;
  import hub75_scan_pkg::*;

  localparam int unsigned N_BANKS  = 2;
  localparam int unsigned N_ROWS   = 4;
  localparam int unsigned N_COLS   = 4;
  localparam int unsigned N_CHANS  = 3;
  localparam int unsigned N_PLANES = 3;
  localparam int unsigned LR       = 2;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned DATA_W   = N_BANKS * N_CHANS;

  typedef struct {
    int addr;
    int inc;
    int rstp;
    int fd;
  } latch_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       ctrl_run;
  logic [7:0] cfg;

  int tests = 0;
  int fails = 0;
  int le_count = 0;
  int fd_count = 0;
  int inc_count = 0;
  int rst_count = 0;
  int model_addr = 0;

  int     exp_data_q[$];
  int     exp_run_q[$];
  latch_t exp_latch_q[$];

  hub75_scan_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROW_W(LR)) bus ();

  hub75_scan #(
    .N_BANKS(N_BANKS), .N_ROWS(N_ROWS), .N_COLS(N_COLS),
    .N_CHANS(N_CHANS), .N_PLANES(N_PLANES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ctrl_run_i    (ctrl_run),
    .cfg_bcm_len_i (cfg),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // Line buffer model: data = read address, returned one cycle after the strobe.
  always @(posedge clk) begin
    bus.buf_rd_data <= bus.buf_rd_en ? DATA_W'(bus.buf_rd_addr) : '0;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor / scoreboard.
  initial begin
    int     clk_cnt = 0;
    int     run_len = 0;
    int     fd_pending = 0;
    int     prev_rd_en = 0;
    int     prev_rd_addr = 0;
    int     last_addr = 0;
    int     e;
    latch_t l;
    forever begin
      @(negedge clk);
      if (rst) begin
        clk_cnt = 0; run_len = 0; fd_pending = 0; prev_rd_en = 0; last_addr = 0;
      end else begin
        if (bus.frame_done || fd_pending != 0) check("frame_done", int'(bus.frame_done), fd_pending);
        if (bus.frame_done) fd_count++;
        fd_pending = 0;

        if (bus.phy_clk) begin
          check("rd_en_before_clk", prev_rd_en, 1);
          if (exp_data_q.size() == 0) begin
            check("unexpected_shift", int'(bus.phy_data), -1);
          end else begin
            e = exp_data_q.pop_front();
            check("phy_data", int'(bus.phy_data), e);
            check("rd_addr", prev_rd_addr, e);
          end
          clk_cnt++;
        end

        if (bus.phy_le) begin
          check("le_with_clk", int'(bus.phy_clk), 0);
          check("le_blank", int'(bus.phy_blank), 1);
          check("shift_len_at_le", clk_cnt, N_COLS);
          clk_cnt = 0;
          le_count++;
          if (exp_latch_q.size() == 0) begin
            check("unexpected_latch", int'(bus.phy_addr), -1);
          end else begin
            l = exp_latch_q.pop_front();
            check("phy_addr", int'(bus.phy_addr), l.addr);
            check("phy_addr_inc", int'(bus.phy_addr_inc), l.inc);
            check("phy_addr_rst", int'(bus.phy_addr_rst), l.rstp);
            fd_pending = l.fd;
          end
        end else if (bus.phy_addr_inc || bus.phy_addr_rst) begin
          check("addr_pulse_outside_latch", 1, 0);
        end
        if (bus.phy_addr_inc) inc_count++;
        if (bus.phy_addr_rst) rst_count++;

        if (!bus.phy_blank) begin
          if (int'(bus.phy_addr) != last_addr) check("addr_change_while_lit", int'(bus.phy_addr), last_addr);
          run_len++;
        end else if (run_len != 0) begin
          if (exp_run_q.size() == 0) begin
            check("unexpected_lit_run", run_len, 0);
          end else begin
            e = exp_run_q.pop_front();
            check("lit_run_len", run_len, e);
          end
          run_len = 0;
        end

        last_addr    = int'(bus.phy_addr);
        prev_rd_en   = int'(bus.buf_rd_en);
        prev_rd_addr = int'(bus.buf_rd_addr);
      end
    end
  end

  // Expected responses for n lines starting at (row 0, plane 0).
  task automatic push_lines(input int n, input int cfg_v);
    latch_t l;
    for (int i = 0; i < n; i++) begin
      int r = (i / N_PLANES) % N_ROWS;
      int p = i % N_PLANES;
      for (int c = 0; c < N_COLS; c++) exp_data_q.push_back(r * 16 + p * 4 + c);
      exp_run_q.push_back((cfg_v + 1) << p);
      l.addr = r;
      l.inc  = (r != model_addr && r != 0) ? 1 : 0;
      l.rstp = (r != model_addr && r == 0) ? 1 : 0;
      l.fd   = (r == N_ROWS - 1 && p == N_PLANES - 1) ? 1 : 0;
      exp_latch_q.push_back(l);
      model_addr = r;
    end
  endtask

  task automatic wait_le(input int target, input int budget);
    int k = 0;
    while (le_count < target && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (le_count < target) check("le_timeout", le_count, target);
  endtask

  task automatic wait_clk_pulses(input int n, input int budget);
    int seen = 0;
    int k = 0;
    while (seen < n && k < budget) begin
      @(posedge clk); #1;
      if (bus.phy_clk) seen++;
      k++;
    end
    if (seen < n) check("phy_clk_timeout", seen, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_blank"},    int'(bus.phy_blank), 1);
    check({tag, "_le"},       int'(bus.phy_le), 0);
    check({tag, "_clk"},      int'(bus.phy_clk), 0);
    check({tag, "_rd_en"},    int'(bus.buf_rd_en), 0);
    check({tag, "_inc"},      int'(bus.phy_addr_inc), 0);
    check({tag, "_rstp"},     int'(bus.phy_addr_rst), 0);
    check({tag, "_fd"},       int'(bus.frame_done), 0);
    check({tag, "_data"},     int'(bus.phy_data), 0);
    check({tag, "_addr"},     int'(bus.phy_addr), 0);
  endtask

  // Run n lines from (0,0); ctrl_run drops during the last line's shift.
  task automatic run_lines(input int n, input int cfg_v);
    int start = le_count;
    push_lines(n, cfg_v);
    cfg      = 8'(cfg_v);
    ctrl_run = 1'b1;
    wait_le(start + n - 1, 3000);
    wait_clk_pulses(1, 200);
    ctrl_run = 1'b0;
    wait_le(start + n, 3000);
    cfg = 8'(cfg_v) ^ 8'hA5;   // must not affect the draining plane
    repeat (((cfg_v + 1) << (N_PLANES - 1)) + 20) @(posedge clk);
    #1;
    check("data_queue_drained", exp_data_q.size(), 0);
    check("run_queue_drained", exp_run_q.size(), 0);
    check("latch_queue_drained", exp_latch_q.size(), 0);
    check("idle_blank", int'(bus.phy_blank), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol;
    int start;
    rst = 1'b1;
    ctrl_run = 1'b0;
    cfg = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");

    // Idle with ctrl_run low.
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (!bus.phy_blank || bus.buf_rd_en || bus.phy_clk || bus.phy_le) viol++;
    end
    check("idle_quiet_cycles", viol, 0);

    // Full frame, on-time 10 cycles per LSB: runs 10/20/40, rows 0..3, one frame_done.
    run_lines(12, 9);

    // LSB on-time 1: lit shorter than shift, wraps past the frame end to row 0.
    run_lines(14, 0);

    // Reset in the middle of the second line's shift.
    push_lines(2, 0);
    cfg      = 8'd0;
    start    = le_count;
    ctrl_run = 1'b1;
    wait_le(start + 1, 500);
    wait_clk_pulses(2, 100);
    rst      = 1'b1;
    ctrl_run = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midshift_reset");
    rst = 1'b0;
    exp_data_q.delete();
    exp_run_q.delete();
    exp_latch_q.delete();
    model_addr = 0;
    repeat (20) @(posedge clk);
    #1;
    check("post_reset_no_latch", le_count, start + 1);
    check("post_reset_no_read", int'(bus.buf_rd_en), 0);

    // Restart must begin at (0,0).
    run_lines(3, 2);

    check("frame_done_total", fd_count, 2);
    check("addr_inc_total", inc_count, 6);
    check("addr_rst_total", rst_count, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
